// File: rtl/flit_fmt_pkg.sv
// Flit field positions and assembler FSM states shared by the flit assembler
// and the depacketizer so both sides agree on packet layout.
package flit_fmt_pkg;

  typedef enum logic {IDLE = 1'b0, HAVE_HEAD = 1'b1} asm_state_e;

  function automatic int valid_bit(input int wf);
    return wf - 1;
  endfunction

  function automatic int head_bit(input int wf);
    return wf - 2;
  endfunction

  function automatic int tail_bit(input int wf);
    return wf - 3;
  endfunction

  function automatic int vc_msb(input int wf);
    return wf - 4;
  endfunction

  function automatic int payload_w(input int wf, input int vcw);
    return wf - 3 - vcw;
  endfunction

endpackage

// File: rtl/flit_assembler_1_sub_pkt_out_reg.sv
// One-entry valid/ready output register (module pkt_out_reg); the producer
// loads only when in_ready is high, so a held packet is never overwritten.
module pkt_out_reg #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         in_ready,
  output logic [W-1:0] data_out,
  output logic         valid_out,
  input  logic         ready_in
);

  logic [W-1:0] data_q, data_d;
  logic         valid_q, valid_d;

  assign in_ready  = ~valid_q | ready_in;
  assign data_out  = data_q;
  assign valid_out = valid_q;

  always_comb begin
    valid_d = load | (valid_q & ~ready_in);
    data_d  = load ? load_data : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/flit_assembler_1_sub.sv
// Reassembles head+tail flits into one packet word, forwards single-flit
// packets, drops malformed flits. FLIT_ASM_ERRCNT_EN adds a saturating err_cnt_out.
module flit_assembler_1_sub
  import flit_fmt_pkg::*;
#(
  parameter int WIDTH_PKT        = 36,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int ADDRESS_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH_PKT/2-1:0] flit_in,
  input  logic                   flit_valid_in,
  output logic                   flit_ready_out,
  output logic [WIDTH_PKT-1:0]   data_out,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic                   err_out
`ifdef FLIT_ASM_ERRCNT_EN
  ,
  output logic [15:0]            err_cnt_out
`endif
);

  localparam int WF  = WIDTH_PKT / 2;
  localparam int VCW = VC_ADDRESS_WIDTH;
  localparam int VB  = valid_bit(WF);
  localparam int HB  = head_bit(WF);
  localparam int TB  = tail_bit(WF);
  localparam int VCM = vc_msb(WF);

  if ((WIDTH_PKT % 2 != 0) || (ADDRESS_WIDTH > payload_w(WF, VCW))) begin : g_cfg_chk
    $error("flit_assembler_1_sub: WIDTH_PKT must be even and hold the header fields");
  end

  asm_state_e     state_q, state_d;
  logic [WF-1:0]  head_q, head_d;
  logic [VCW-1:0] vc_q, vc_d;
  logic           err_q, err_d;
  logic           load, out_free, writes_out, accept;
  logic [WIDTH_PKT-1:0] load_data;

  logic           f_valid, f_head, f_tail;
  logic [VCW-1:0] f_vc;

  assign f_valid = flit_in[VB];
  assign f_head  = flit_in[HB];
  assign f_tail  = flit_in[TB];
  assign f_vc    = flit_in[VCM -: VCW];

  // Only flits that would load the output register can be back-pressured.
  assign writes_out = f_valid & ((f_head & f_tail) |
                      ((state_q == HAVE_HEAD) & ~f_head & f_tail & (f_vc == vc_q)));
  assign flit_ready_out = ~writes_out | out_free;
  assign accept         = flit_valid_in & flit_ready_out;

  always_comb begin
    state_d   = state_q;
    head_d    = head_q;
    vc_d      = vc_q;
    err_d     = 1'b0;
    load      = 1'b0;
    load_data = '0;
    if (accept && f_valid) begin
      if (f_head) begin
        // A new head always supersedes a held one; the held one is an error.
        err_d = (state_q == HAVE_HEAD);
        if (f_tail) begin
          load      = 1'b1;
          load_data = {flit_in, {WF{1'b0}}};
          state_d   = IDLE;
        end else begin
          head_d  = flit_in;
          vc_d    = f_vc;
          state_d = HAVE_HEAD;
        end
      end else if (state_q == HAVE_HEAD && f_tail && f_vc == vc_q) begin
        load      = 1'b1;
        load_data = {head_q, flit_in};
        state_d   = IDLE;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= '0;
      vc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      vc_q    <= vc_d;
      err_q   <= err_d;
    end
  end

  assign err_out = err_q;

`ifdef FLIT_ASM_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_out = err_cnt_q;
`endif

  pkt_out_reg #(.W(WIDTH_PKT)) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .in_ready  (out_free),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

endmodule

// File: tb/tb_flit_assembler_1_sub.sv
// Table vectors, directed corner sequences and a queue-based random model
// for flit_assembler_1_sub.
module tb_flit_assembler_1_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic [17:0] flit_in;
  logic        flit_valid_in;
  logic        flit_ready_out;
  logic [35:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic        err_out;
`ifdef FLIT_ASM_ERRCNT_EN
  logic [15:0] err_cnt_out;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  flit_assembler_1_sub dut (
    .clk            (clk),
    .rst            (rst),
    .flit_in        (flit_in),
    .flit_valid_in  (flit_valid_in),
    .flit_ready_out (flit_ready_out),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .ready_in       (ready_in),
    .err_out        (err_out)
`ifdef FLIT_ASM_ERRCNT_EN
    ,
    .err_cnt_out    (err_cnt_out)
`endif
  );

  typedef struct packed {
    logic [17:0] f;
    logic        v;
    logic        r;
    logic        er;
    logic        ev;
    logic [35:0] ed;
    logic        ee;
  } vec_t;

  function automatic logic [17:0] mk(input logic h, input logic t, input logic vc,
                                     input logic [13:0] p);
    return {1'b1, h, t, vc, p};
  endfunction

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle, check ready before the edge and outputs after it.
  task automatic tstep(input string nm, input logic [17:0] f, input logic v, input logic r,
                       input logic er, input logic ev, input logic [35:0] ed, input logic ee);
    @(negedge clk);
    flit_in = f; flit_valid_in = v; ready_in = r;
    #1 chk({nm, ".ready"}, flit_ready_out, er);
    @(posedge clk);
    #1;
    chk({nm, ".valid"}, valid_out, ev);
    chk({nm, ".err"}, err_out, ee);
    if (ev) chk({nm, ".data"}, data_out, ed);
  endtask

  task automatic do_reset();
    rst = 1'b1; flit_in = '0; flit_valid_in = 1'b0; ready_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  vec_t vt[14];
  logic [17:0] h1, t1, h9, t12, s[4], h2, t2, hx;
  logic [17:0] part[$];
  logic [35:0] outq[$];

  initial begin
    h1  = mk(1, 0, 0, 14'h1A5);
    t1  = mk(0, 1, 0, 14'h0F3);
    h9  = mk(1, 0, 0, 14'h2B7);
    t12 = mk(0, 1, 0, 14'h066);
    for (int i = 0; i < 4; i++) s[i] = mk(1, 1, i[0], 14'h100 + 14'(i));

    vt[0]  = '{h1, 1'b1, 1'b1, 1'b1, 1'b0, 36'h0, 1'b0};
    vt[1]  = '{t1, 1'b1, 1'b1, 1'b1, 1'b1, {h1, t1}, 1'b0};
    vt[2]  = '{18'h0, 1'b0, 1'b1, 1'b1, 1'b0, 36'h0, 1'b0};
    for (int i = 0; i < 4; i++)
      vt[3+i] = '{s[i], 1'b1, 1'b1, 1'b1, 1'b1, {s[i], 18'h0}, 1'b0};
    vt[7]  = '{18'h0, 1'b0, 1'b1, 1'b1, 1'b0, 36'h0, 1'b0};
    vt[8]  = '{mk(0, 1, 0, 14'h011), 1'b1, 1'b1, 1'b1, 1'b0, 36'h0, 1'b1};
    vt[9]  = '{h9, 1'b1, 1'b1, 1'b1, 1'b0, 36'h0, 1'b0};
    vt[10] = '{mk(0, 1, 1, 14'h055), 1'b1, 1'b1, 1'b1, 1'b0, 36'h0, 1'b1};
    vt[11] = '{{4'b0110, 14'h3FF}, 1'b1, 1'b1, 1'b1, 1'b0, 36'h0, 1'b0};
    vt[12] = '{t12, 1'b1, 1'b1, 1'b1, 1'b1, {h9, t12}, 1'b0};
    vt[13] = '{18'h0, 1'b0, 1'b1, 1'b1, 1'b0, 36'h0, 1'b0};

    do_reset();
    #1;
    chk("reset.valid", valid_out, 1'b0);
    chk("reset.data", data_out, 36'h0);
    chk("reset.err", err_out, 1'b0);
    chk("reset.ready", flit_ready_out, 1'b1);

    for (int i = 0; i < 14; i++)
      tstep($sformatf("vec%0d", i), vt[i].f, vt[i].v, vt[i].r, vt[i].er, vt[i].ev, vt[i].ed, vt[i].ee);

    // Back-pressure: held packet stays put, completing tail waits, then no bubble.
    h2 = mk(1, 0, 1, 14'h0AA);
    t2 = mk(0, 1, 1, 14'h0BB);
    tstep("bp.head", h1, 1, 0, 1, 0, 0, 0);
    tstep("bp.tail", t1, 1, 0, 1, 1, {h1, t1}, 0);
    tstep("bp.head2", h2, 1, 0, 1, 1, {h1, t1}, 0);
    tstep("bp.wait1", t2, 1, 0, 0, 1, {h1, t1}, 0);
    tstep("bp.wait2", t2, 1, 0, 0, 1, {h1, t1}, 0);
    tstep("bp.go", t2, 1, 1, 1, 1, {h2, t2}, 0);
    tstep("bp.drain", 18'h0, 0, 1, 1, 0, 0, 0);

    // Head superseded by a second head.
    begin
`ifdef FLIT_ASM_ERRCNT_EN
      logic [15:0] c0;
      c0 = err_cnt_out;
`endif
      tstep("hh.h1", h1, 1, 1, 1, 0, 0, 0);
      tstep("hh.h2", h2, 1, 1, 1, 0, 0, 1);
      tstep("hh.t", t2, 1, 1, 1, 1, {h2, t2}, 0);
`ifdef FLIT_ASM_ERRCNT_EN
      chk("hh.errcnt", err_cnt_out, c0 + 16'd1);
`endif
    end
    tstep("hh.drain", 18'h0, 0, 1, 1, 0, 0, 0);

    // Asynchronous reset between head and tail with a packet still held.
    hx = mk(1, 0, 0, 14'h123);
    tstep("rs.h", h1, 1, 0, 1, 0, 0, 0);
    tstep("rs.t", t1, 1, 0, 1, 1, {h1, t1}, 0);
    tstep("rs.hx", hx, 1, 0, 1, 1, {h1, t1}, 0);
    @(negedge clk);
    flit_valid_in = 1'b0;
    #2 rst = 1'b1;
    #1 chk("rs.async_valid", valid_out, 1'b0);
    @(negedge clk) rst = 1'b0;
    tstep("rs.orphan", mk(0, 1, 0, 14'h0CC), 1, 1, 1, 0, 0, 1);
    tstep("rs.after", 18'h0, 0, 1, 1, 0, 0, 0);

    // Random traffic against a queue model of held head and output slot.
    do_reset();
    part.delete();
    outq.delete();
    for (int c = 0; c < 3000; c++) begin
      logic [17:0] f;
      logic v, r, comp, exp_rdy, merr;
      @(negedge clk);
      f = {($urandom_range(0, 9) != 0), 3'($urandom), 14'($urandom)};
      v = ($urandom_range(0, 4) != 0);
      r = ($urandom_range(0, 9) < 7);
      flit_in = f; flit_valid_in = v; ready_in = r;
      comp = f[17] && ((f[16] && f[15]) ||
             (part.size() != 0 && !f[16] && f[15] && f[14] == part[0][14]));
      exp_rdy = !comp || outq.size() == 0 || r;
      #1 chk("rnd.ready", flit_ready_out, exp_rdy);
      if (outq.size() != 0 && r) void'(outq.pop_front());
      merr = 1'b0;
      if (v && exp_rdy && f[17]) begin
        if (f[16]) begin
          if (part.size() != 0) begin merr = 1'b1; part.delete(); end
          if (f[15]) outq.push_back({f, 18'h0});
          else part.push_back(f);
        end else if (f[15] && part.size() != 0 && f[14] == part[0][14]) begin
          outq.push_back({part[0], f});
          part.delete();
        end else begin
          merr = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      chk("rnd.valid", valid_out, outq.size() != 0);
      chk("rnd.err", err_out, merr);
      if (outq.size() != 0) chk("rnd.data", data_out, outq[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
